// File: rtl/i2c_master_arb.sv
// Two-requester I2C master for a 12-bit register slave.
// Round-robin arbitration between two on-chip requesters, then one complete
// transaction: START, address+R/W, two data bytes, STOP. A 12-bit value is
// carried as byte1 = data[11:4], byte2 = {data[3:0], 4'b0000}.
//
// Ports:
//   clk, rst_n   system clock, asynchronous active-low reset
//   req[1:0]     request level per requester
//   rnw[1:0]     direction per requester (1 = read)
//   wdata[23:0]  write data, [11:0] requester 0, [23:12] requester 1
//   gnt[1:0]     one-hot grant, held for the whole transaction
//   done         one-cycle pulse on the last cycle of STOP
//   nack         last transaction aborted by a slave NACK
//   rdata[11:0]  last successfully read value
//   busy         high from grant until done, inclusive
//   scl          push-pull bus clock
//   sda          open-drain data (drives 0 or releases)
module i2c_master_arb #(
    parameter int unsigned CLK_DIV    = 4,
    parameter logic [6:0]  SLAVE_ADDR = 7'd7
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req,
    input  logic [1:0]  rnw,
    input  logic [23:0] wdata,
    output logic [1:0]  gnt,
    output logic        done,
    output logic        nack,
    output logic [11:0] rdata,
    output logic        busy,
    output logic        scl,
    inout  wire         sda
);

    localparam int unsigned BIT_CYC = 4 * CLK_DIV;
    localparam int unsigned CW      = $clog2(BIT_CYC);
    typedef logic [CW-1:0] cnt_t;

    localparam cnt_t CYC_LAST     = cnt_t'(BIT_CYC - 1);
    localparam cnt_t CYC_Q2_PRE   = cnt_t'(2 * CLK_DIV - 1);
    localparam cnt_t CYC_Q3_PRE   = cnt_t'(3 * CLK_DIV - 1);
    localparam cnt_t CYC_DONE_PRE = cnt_t'(BIT_CYC - 2);

    typedef enum logic [2:0] {StIdle, StStart, StAddr, StByte1, StByte2, StStop} state_t;

    state_t      state;
    cnt_t        cyc;
    logic [3:0]  bitcnt;
    cnt_t        free_cnt;
    logic        last_grant;
    logic        lat_rnw;
    logic [11:0] lat_data;
    logic        nack_flag;
    logic [11:0] rx;
    logic        sda_low;
    logic [1:0]  sda_sync;

    // Next-bit decode used at the end of each bit time
    state_t      adv_state;
    logic [3:0]  adv_bit;
    logic        adv_nack;
    logic        adv_low;
    logic [7:0]  tx_byte;
    logic        win;
    logic        sample;

    assign sda    = sda_low ? 1'b0 : 1'bz;
    assign sample = sda_sync[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sda_sync <= 2'b11;
        end else begin
            sda_sync <= {sda_sync[0], sda};
        end
    end

    // Both requesting: the one not granted last wins
    always_comb begin
        win = (req == 2'b11) ? ~last_grant : req[1];
    end

    always_comb begin
        adv_state = state;
        adv_bit   = bitcnt + 4'd1;
        adv_nack  = 1'b0;
        case (state)
            StStart: begin
                adv_state = StAddr;
                adv_bit   = 4'd0;
            end
            StAddr: begin
                if (bitcnt == 4'd8) begin
                    adv_bit = 4'd0;
                    if (sample) begin
                        adv_state = StStop;
                        adv_nack  = 1'b1;
                    end else begin
                        adv_state = StByte1;
                    end
                end
            end
            StByte1: begin
                if (bitcnt == 4'd8) begin
                    adv_bit = 4'd0;
                    if (!lat_rnw && sample) begin
                        adv_state = StStop;
                        adv_nack  = 1'b1;
                    end else begin
                        adv_state = StByte2;
                    end
                end
            end
            StByte2: begin
                if (bitcnt == 4'd8) begin
                    adv_bit   = 4'd0;
                    adv_state = StStop;
                    adv_nack  = !lat_rnw && sample;
                end
            end
            default: begin
                adv_state = StIdle;
                adv_bit   = 4'd0;
            end
        endcase

        case (adv_state)
            StAddr:  tx_byte = {SLAVE_ADDR, lat_rnw};
            StByte1: tx_byte = lat_data[11:4];
            StByte2: tx_byte = {lat_data[3:0], 4'b0000};
            default: tx_byte = 8'h00;
        endcase

        if (adv_state == StStop) begin
            adv_low = 1'b1;
        end else if (adv_bit == 4'd8) begin
            // Ninth bit: release for slave ACK, or master ACK after a read byte1
            adv_low = (adv_state == StByte1) && lat_rnw;
        end else if ((adv_state == StAddr) || !lat_rnw) begin
            adv_low = ~tx_byte[~adv_bit[2:0]];
        end else begin
            adv_low = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= StIdle;
            cyc        <= '0;
            bitcnt     <= '0;
            free_cnt   <= '0;
            last_grant <= 1'b1;
            lat_rnw    <= 1'b0;
            lat_data   <= '0;
            nack_flag  <= 1'b0;
            rx         <= '0;
            sda_low    <= 1'b0;
            gnt        <= '0;
            done       <= 1'b0;
            nack       <= 1'b0;
            rdata      <= '0;
            busy       <= 1'b0;
            scl        <= 1'b1;
        end else begin
            done <= 1'b0;
            case (state)
                StIdle: begin
                    if (free_cnt != CYC_LAST) begin
                        free_cnt <= free_cnt + cnt_t'(1);
                    end else if (req != 2'b00) begin
                        gnt        <= win ? 2'b10 : 2'b01;
                        last_grant <= win;
                        busy       <= 1'b1;
                        lat_rnw    <= rnw[win];
                        lat_data   <= win ? wdata[23:12] : wdata[11:0];
                        nack_flag  <= 1'b0;
                        state      <= StStart;
                        cyc        <= '0;
                        bitcnt     <= '0;
                        scl        <= 1'b1;
                        sda_low    <= 1'b0;
                    end
                end
                StStop: begin
                    cyc <= cyc + cnt_t'(1);
                    if (cyc == CYC_Q2_PRE) scl <= 1'b1;
                    if (cyc == CYC_Q3_PRE) sda_low <= 1'b0;
                    if (cyc == CYC_DONE_PRE) begin
                        done <= 1'b1;
                        nack <= nack_flag;
                        if (lat_rnw && !nack_flag) rdata <= rx;
                    end
                    if (cyc == CYC_LAST) begin
                        state    <= StIdle;
                        gnt      <= '0;
                        busy     <= 1'b0;
                        free_cnt <= '0;
                        cyc      <= '0;
                    end
                end
                default: begin
                    cyc <= cyc + cnt_t'(1);
                    if (cyc == CYC_Q2_PRE) begin
                        // START pulls SDA low while SCL stays high
                        if (state == StStart) sda_low <= 1'b1;
                        else                  scl     <= 1'b1;
                    end
                    if (cyc == CYC_LAST) begin
                        cyc     <= '0;
                        state   <= adv_state;
                        bitcnt  <= adv_bit;
                        scl     <= 1'b0;
                        sda_low <= adv_low;
                        if (adv_nack) nack_flag <= 1'b1;
                        // Keep byte1 and the high nibble of byte2 only
                        if (lat_rnw && (((state == StByte1) && (bitcnt < 4'd8)) ||
                                        ((state == StByte2) && (bitcnt < 4'd4)))) begin
                            rx <= {rx[10:0], sample};
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_master_arb.sv
module tb_i2c_master_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req;
    logic [1:0]  rnw;
    logic [23:0] wdata;
    logic [1:0]  gnt;
    logic        done;
    logic        nack;
    logic [11:0] rdata;
    logic        busy;
    logic        scl;
    wire         sda;

    logic        slave_low = 1'b0;
    pullup (sda);
    assign sda = slave_low ? 1'b0 : 1'bz;

    i2c_master_arb #(.CLK_DIV(4), .SLAVE_ADDR(7'd7)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .rnw   (rnw),
        .wdata (wdata),
        .gnt   (gnt),
        .done  (done),
        .nack  (nack),
        .rdata (rdata),
        .busy  (busy),
        .scl   (scl),
        .sda   (sda)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  gnt;
        logic        nack;
        logic [11:0] rdata;
        int          lat;
        int          nbytes;
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [7:0]  b2;
        logic        rd;
    } exp_t;

    exp_t exp_q[$];

    function automatic exp_t mk(input logic [1:0] g, input logic nk, input logic [11:0] rd_v,
                                input int lat, input int nb, input logic [7:0] a,
                                input logic [7:0] x, input logic [7:0] y, input logic rd);
        exp_t e;
        e.gnt = g; e.nack = nk; e.rdata = rd_v; e.lat = lat; e.nbytes = nb;
        e.b0 = a; e.b1 = x; e.b2 = y; e.rd = rd;
        return e;
    endfunction

    // Bus-functional slave
    logic       cfg_ack_addr = 1'b1;
    logic       cfg_nack_b1  = 1'b0;
    logic [7:0] cfg_rd0      = 8'h00;
    logic [7:0] cfg_rd1      = 8'h00;

    logic       in_txn = 1'b0, p_scl = 1'b1, p_sda = 1'b1, s;
    logic       is_read = 1'b0, acked = 1'b0, stop_seen = 1'b0;
    logic       mack1 = 1'b1, mack2 = 1'b1;
    logic [7:0] sh = 8'h00, rd_b;
    logic [7:0] got [3];
    int         cnt = 0, bidx = 0;

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_txn = 1'b0; slave_low = 1'b0; p_scl = 1'b1; p_sda = 1'b1;
        end else begin
            s = (sda === 1'b0) ? 1'b0 : 1'b1;
            if (p_scl && scl && p_sda && !s) begin
                in_txn = 1'b1; cnt = 0; bidx = 0; acked = 1'b0; is_read = 1'b0;
                stop_seen = 1'b0; mack1 = 1'b1; mack2 = 1'b1;
                for (int i = 0; i < 3; i++) got[i] = 8'h00;
            end else if (p_scl && scl && !p_sda && s) begin
                in_txn = 1'b0; stop_seen = 1'b1; slave_low = 1'b0;
            end else if (in_txn && !p_scl && scl) begin
                if (cnt < 8) begin
                    sh = {sh[6:0], s};
                    if (cnt == 7 && bidx < 3) begin
                        got[bidx] = sh;
                        if (bidx == 0) is_read = s;
                    end
                end else if (cnt == 8) begin
                    if (bidx == 1) mack1 = s;
                    if (bidx == 2) mack2 = s;
                end
                cnt++;
            end else if (in_txn && p_scl && !scl) begin
                if (cnt == 9) begin
                    cnt = 0; bidx++;
                end
                slave_low = 1'b0;
                if (cnt == 8) begin
                    if (bidx == 0) begin
                        acked     = cfg_ack_addr && (sh[7:1] == 7'd7);
                        slave_low = acked;
                    end else if (!is_read && bidx < 3) begin
                        slave_low = !(bidx == 1 && cfg_nack_b1);
                    end
                end else if (is_read && acked && (bidx == 1 || bidx == 2)) begin
                    rd_b      = (bidx == 1) ? cfg_rd0 : cfg_rd1;
                    slave_low = !rd_b[7-cnt];
                end
            end
            p_scl = scl;
            p_sda = s;
        end
    end

    // Monitor: pops one expectation per done
    logic [1:0] prev_gnt = 2'b00;
    logic       gap_valid = 1'b0, post_chk = 1'b0;
    int         t_start = 0, last_done = 0;
    exp_t       e;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_gnt = 2'b00; gap_valid = 1'b0; post_chk = 1'b0;
        end else begin
            if (post_chk) begin
                check("gnt_after_done", 32'(gnt), 32'(0));
                check("busy_after_done", 32'(busy), 32'(0));
                post_chk = 1'b0;
            end
            if (gnt != 2'b00 && prev_gnt == 2'b00) begin
                t_start = cyc;
                if (gap_valid) check("bus_free_gap_ge_16", 32'((t_start - last_done) >= 16), 32'(1));
            end
            prev_gnt = gnt;
            if (done) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL unexpected_done: got done at cycle %0d, required none", cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("gnt_at_done", 32'(gnt), 32'(e.gnt));
                    check("busy_at_done", 32'(busy), 32'(1));
                    check("nack", 32'(nack), 32'(e.nack));
                    check("rdata", 32'(rdata), 32'(e.rdata));
                    check("done_latency", 32'(cyc - t_start), 32'(e.lat));
                    check("stop_seen", 32'(stop_seen), 32'(1));
                    check("addr_byte", 32'(got[0]), 32'(e.b0));
                    if (e.nbytes > 1) check("byte1", 32'(got[1]), 32'(e.b1));
                    if (e.nbytes > 2) check("byte2", 32'(got[2]), 32'(e.b2));
                    if (e.rd && e.nbytes == 3) begin
                        check("master_ack_byte1", 32'(mack1), 32'(0));
                        check("master_nack_byte2", 32'(mack2), 32'(1));
                    end
                end
                last_done = cyc; gap_valid = 1'b1; post_chk = 1'b1;
            end
        end
    end

    task automatic wait_gnt();
        bit ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (gnt != 2'b00) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            n_cmp++; n_fail++;
            $display("FAIL grant_timeout: got no grant, required one within 100 cycles");
        end
    endtask

    task automatic wait_done();
        bit ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (done) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            n_cmp++; n_fail++;
            $display("FAIL done_timeout: got no done, required one within 1000 cycles");
        end
    endtask

    // Inputs are scrambled after grant; the latched copies must be used
    task automatic issue(input logic [1:0] r, input logic [1:0] rw, input logic [23:0] wd);
        rnw = rw; wdata = wd; req = r;
        wait_gnt();
        req = 2'b00; rnw = ~rw; wdata = ~wd;
        wait_done();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; req = 2'b00; rnw = 2'b00; wdata = '0;
        repeat (3) @(negedge clk);
        check("rst_gnt", 32'(gnt), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_nack", 32'(nack), 32'(0));
        check("rst_rdata", 32'(rdata), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_scl", 32'(scl), 32'(1));
        check("rst_sda", 32'(sda === 1'b1), 32'(1));
        rst_n = 1'b1;

        // Arbitration with both requesting: 01, 10, 01
        exp_q.push_back(mk(2'b01, 1'b0, 12'h000, 463, 3, 8'h0E, 8'h11, 8'h10, 1'b0));
        exp_q.push_back(mk(2'b10, 1'b0, 12'h000, 463, 3, 8'h0E, 8'h22, 8'h20, 1'b0));
        exp_q.push_back(mk(2'b01, 1'b0, 12'h000, 463, 3, 8'h0E, 8'h11, 8'h10, 1'b0));
        rnw = 2'b00; wdata = {12'h222, 12'h111}; req = 2'b11;
        for (int k = 0; k < 3; k++) begin
            wait_gnt();
            if (k == 2) req = 2'b00;
            wait_done();
        end
        @(negedge clk);

        // Write 0xA5C from requester 0
        exp_q.push_back(mk(2'b01, 1'b0, 12'h000, 463, 3, 8'h0E, 8'hA5, 8'hC0, 1'b0));
        issue(2'b01, 2'b00, {12'h000, 12'hA5C});

        // Read from requester 1, slave returns 0x3E, 0x7F
        cfg_rd0 = 8'h3E; cfg_rd1 = 8'h7F;
        exp_q.push_back(mk(2'b10, 1'b0, 12'h3E7, 463, 3, 8'h0F, 8'h3E, 8'h7F, 1'b1));
        issue(2'b10, 2'b10, 24'h000000);

        // Address NACK on a read: rdata keeps 0x3E7
        cfg_ack_addr = 1'b0;
        exp_q.push_back(mk(2'b01, 1'b1, 12'h3E7, 175, 1, 8'h0F, 8'h00, 8'h00, 1'b1));
        issue(2'b01, 2'b01, 24'h000000);
        cfg_ack_addr = 1'b1;

        // Write NACKed on byte1
        cfg_nack_b1 = 1'b1;
        exp_q.push_back(mk(2'b10, 1'b1, 12'h3E7, 319, 2, 8'h0E, 8'h5A, 8'h00, 1'b0));
        issue(2'b10, 2'b00, {12'h5A5, 12'h000});
        cfg_nack_b1 = 1'b0;

        // ACKed write clears nack
        exp_q.push_back(mk(2'b01, 1'b0, 12'h3E7, 463, 3, 8'h0E, 8'h0F, 8'h00, 1'b0));
        issue(2'b01, 2'b00, {12'h000, 12'h0F0});

        // Reset in the middle of BYTE1 of a write
        rnw = 2'b00; wdata = {12'h777, 12'h000}; req = 2'b10;
        wait_gnt();
        req = 2'b00;
        repeat (180) @(negedge clk);
        check("busy_before_reset", 32'(busy), 32'(1));
        #2 rst_n = 1'b0;
        #1;
        check("midrst_scl", 32'(scl), 32'(1));
        check("midrst_sda", 32'(sda === 1'b1), 32'(1));
        check("midrst_gnt", 32'(gnt), 32'(0));
        check("midrst_busy", 32'(busy), 32'(0));
        check("midrst_nack", 32'(nack), 32'(0));
        check("midrst_rdata", 32'(rdata), 32'(0));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        exp_q.push_back(mk(2'b01, 1'b0, 12'h000, 463, 3, 8'h0E, 8'h12, 8'h30, 1'b0));
        issue(2'b01, 2'b00, {12'h000, 12'h123});

        repeat (5) @(negedge clk);
        check("all_expected_done", 32'(exp_q.size()), 32'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got no end of test, required finish before time limit");
        $fatal(1, "watchdog");
    end

endmodule
